// File: rtl/hazard_ctrl.sv
// Central stall/bubble scheduler for the 5-stage pipeline.
// Sequences multi-cycle MUL/DIV and resolves hazards by fixed priority.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] d_src1,
    input  logic [4:0] d_src2,
    input  logic       d_isJumpInstr,
    input  logic [4:0] e_dst,
    input  logic       e_isLoad,
    input  logic       e_md_start,
    input  logic       e_md_isDiv,
    input  logic       i_req,
    input  logic       i_data_ok,
    input  logic       m_req,
    input  logic       m_data_ok,
    input  logic       exception,
    output logic       F_stall,
    output logic       D_stall,
    output logic       E_stall,
    output logic       M_stall,
    output logic       D_bubble,
    output logic       E_bubble,
    output logic       M_bubble,
    output logic       W_bubble,
    output logic       md_busy,
    output logic       md_done
);

    localparam int CW = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic e_stall;
        logic m_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_bubble;
        logic md_busy;
        logic md_done;
    } ctl_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] cnt_ld;

    logic m_wait;
    logic i_wait;
    logic lu;
    logic md_stall;
    logic md_fin;
    ctl_t ctl;

    assign m_wait = m_req & ~m_data_ok;
    assign i_wait = i_req & ~i_data_ok;

    // Register 0 is hardwired, so a load to it never creates a hazard.
    assign lu = e_isLoad && (e_dst != 5'd0) &&
                ((e_dst == d_src1) || (e_dst == d_src2));

    assign md_stall = ((state == RUN) && e_md_start) ||
                      ((state == MD_WAIT) && (cnt != '0)) ||
                      ((state == MD_WAIT) && (cnt == '0) && m_wait);

    assign md_fin = (state == MD_WAIT) && (cnt == '0) && !m_wait;

    assign cnt_ld = e_md_isDiv ? CW'(DIV_LAT - 2) : CW'(MUL_LAT - 2);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The MUL/DIV counter free-runs under a memory wait; only the
    // final release is held back.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (exception) begin
            state_nx = FLUSH;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (e_md_start) begin
                        state_nx = MD_WAIT;
                        cnt_nx   = cnt_ld;
                    end
                end
                MD_WAIT: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - 1'b1;
                    end else if (!m_wait) begin
                        state_nx = RUN;
                    end
                end
                FLUSH: begin
                    state_nx = RUN;
                end
                default: begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_comb begin
        ctl = '0;
        if (!resetn) begin
            ctl.d_bubble = 1'b1;
            ctl.e_bubble = 1'b1;
            ctl.m_bubble = 1'b1;
            ctl.w_bubble = 1'b1;
        end else begin
            priority case (1'b1)
                exception: begin
                    ctl.d_bubble = 1'b1;
                    ctl.e_bubble = 1'b1;
                    ctl.m_bubble = 1'b1;
                end
                (state == FLUSH): begin
                    ctl.d_bubble = 1'b1;
                end
                m_wait: begin
                    ctl.f_stall  = 1'b1;
                    ctl.d_stall  = 1'b1;
                    ctl.e_stall  = 1'b1;
                    ctl.m_stall  = 1'b1;
                    ctl.w_bubble = 1'b1;
                end
                md_stall: begin
                    ctl.f_stall  = 1'b1;
                    ctl.d_stall  = 1'b1;
                    ctl.e_stall  = 1'b1;
                    ctl.m_bubble = 1'b1;
                    ctl.md_busy  = 1'b1;
                end
                lu: begin
                    ctl.f_stall  = 1'b1;
                    ctl.d_stall  = 1'b1;
                    ctl.e_bubble = 1'b1;
                end
                // A branch holds in D until its delay slot is fetched.
                (i_wait && d_isJumpInstr): begin
                    ctl.f_stall  = 1'b1;
                    ctl.d_stall  = 1'b1;
                    ctl.e_bubble = 1'b1;
                end
                i_wait: begin
                    ctl.f_stall  = 1'b1;
                    ctl.d_bubble = 1'b1;
                end
                default: begin
                    ctl.f_stall = 1'b0;
                end
            endcase
            ctl.md_done = md_fin && !exception;
        end
    end

    assign F_stall  = ctl.f_stall;
    assign D_stall  = ctl.d_stall;
    assign E_stall  = ctl.e_stall;
    assign M_stall  = ctl.m_stall;
    assign D_bubble = ctl.d_bubble;
    assign E_bubble = ctl.e_bubble;
    assign M_bubble = ctl.m_bubble;
    assign W_bubble = ctl.w_bubble;
    assign md_busy  = ctl.md_busy;
    assign md_done  = ctl.md_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random stimulus
// against a cycle-count reference model.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] d_src1, d_src2, e_dst;
    logic       d_isJumpInstr, e_isLoad, e_md_start, e_md_isDiv;
    logic       i_req, i_data_ok, m_req, m_data_ok, exception;
    logic       F_stall, D_stall, E_stall, M_stall;
    logic       D_bubble, E_bubble, M_bubble, W_bubble;
    logic       md_busy, md_done;
    logic [9:0] dut_out;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed cycles of the mul/div occupying E.
    bit md_active;
    int md_elapsed;
    int md_lat;
    bit flushing;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .resetn(resetn),
        .d_src1(d_src1), .d_src2(d_src2),
        .d_isJumpInstr(d_isJumpInstr),
        .e_dst(e_dst), .e_isLoad(e_isLoad),
        .e_md_start(e_md_start), .e_md_isDiv(e_md_isDiv),
        .i_req(i_req), .i_data_ok(i_data_ok),
        .m_req(m_req), .m_data_ok(m_data_ok),
        .exception(exception),
        .F_stall(F_stall), .D_stall(D_stall),
        .E_stall(E_stall), .M_stall(M_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_bubble(W_bubble),
        .md_busy(md_busy), .md_done(md_done)
    );

    assign dut_out = {F_stall, D_stall, E_stall, M_stall,
                      D_bubble, E_bubble, M_bubble, W_bubble,
                      md_busy, md_done};

    function automatic logic [9:0] model_out();
        bit mw, iw, lu, mds, dn;
        bit fs, ds, es, ms, db, eb, mb, wb, bz;
        if (!resetn) return 10'b0000_1111_00;
        {fs, ds, es, ms, db, eb, mb, wb, bz} = '0;
        mw  = m_req && !m_data_ok;
        iw  = i_req && !i_data_ok;
        lu  = e_isLoad && e_dst != 0 && (e_dst == d_src1 || e_dst == d_src2);
        mds = (!md_active && !flushing && e_md_start) ||
              (md_active && (md_elapsed < md_lat - 1 || mw));
        dn  = md_active && md_elapsed >= md_lat - 1 && !mw && !exception;
        if (exception) begin
            db = 1; eb = 1; mb = 1;
        end else if (flushing) begin
            db = 1;
        end else if (mw) begin
            fs = 1; ds = 1; es = 1; ms = 1; wb = 1;
        end else if (mds) begin
            fs = 1; ds = 1; es = 1; mb = 1; bz = 1;
        end else if (lu || (iw && d_isJumpInstr)) begin
            fs = 1; ds = 1; eb = 1;
        end else if (iw) begin
            fs = 1; db = 1;
        end
        return {fs, ds, es, ms, db, eb, mb, wb, bz, dn};
    endfunction

    task automatic model_tick();
        bit mw;
        mw = m_req && !m_data_ok;
        if (!resetn) begin
            md_active = 0; md_elapsed = 0; flushing = 0;
        end else if (exception) begin
            md_active = 0; md_elapsed = 0; flushing = 1;
        end else if (flushing) begin
            flushing = 0;
        end else if (!md_active) begin
            if (e_md_start) begin
                md_active  = 1;
                md_elapsed = 1;
                md_lat     = e_md_isDiv ? DIV_LAT : MUL_LAT;
            end
        end else if (md_elapsed >= md_lat - 1 && !mw) begin
            md_active = 0;
        end else begin
            md_elapsed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        d_src1 = 0; d_src2 = 0; e_dst = 0;
        d_isJumpInstr = 0; e_isLoad = 0;
        e_md_start = 0; e_md_isDiv = 0;
        i_req = 0; i_data_ok = 0;
        m_req = 0; m_data_ok = 0; exception = 0;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        resetn = 0;
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            #1;
            exp = model_out();
            checks++;
            if (dut_out !== 10'b0000_1111_00 || dut_out !== exp) begin
                errors++;
                $display("FAIL reset c%0d got %b exp %b", c, dut_out, exp);
            end
            tick();
        end
        resetn = 1;
        #1;
        checks++;
        if (dut_out !== 10'b0) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", dut_out, 10'b0);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        e_isLoad = 1; e_dst = 5; d_src2 = 5; d_src1 = 3;
        #1;
        checks++;
        if (dut_out !== 10'b1100_0100_00) begin
            errors++;
            $display("FAIL load_use got %b exp %b", dut_out, 10'b1100_0100_00);
        end
        tick();
        e_dst = 0; d_src2 = 0; d_src1 = 0;
        #1;
        checks++;
        if (dut_out !== 10'b0) begin
            errors++;
            $display("FAIL load_use_r0 got %b exp %b", dut_out, 10'b0);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_mul_div();
        logic [9:0] exp;
        int busy, cyc;
        for (int k = 0; k < 2; k++) begin
            e_md_start = 1;
            e_md_isDiv = (k == 1);
            busy = 0; cyc = 0;
            do begin
                cyc++;
                #1;
                exp = model_out();
                checks++;
                if (dut_out !== exp) begin
                    errors++;
                    $display("FAIL md_seq%0d c%0d got %b exp %b", k, cyc, dut_out, exp);
                end
                if (md_busy) busy++;
                if (md_done) break;
                tick();
            end while (cyc < 40);
            checks++;
            if (!md_done || busy != (k ? DIV_LAT - 1 : MUL_LAT - 1) ||
                cyc != (k ? DIV_LAT : MUL_LAT)) begin
                errors++;
                $display("FAIL md_len%0d got busy=%0d done_cyc=%0d exp busy=%0d done_cyc=%0d",
                         k, busy, cyc, (k ? DIV_LAT - 1 : MUL_LAT - 1),
                         (k ? DIV_LAT : MUL_LAT));
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_div_mwait();
        logic [9:0] exp;
        int cyc;
        e_md_start = 1; e_md_isDiv = 1;
        cyc = 0;
        do begin
            cyc++;
            m_req = (cyc >= 30 && cyc <= 34);
            #1;
            exp = model_out();
            checks++;
            if (dut_out !== exp) begin
                errors++;
                $display("FAIL div_mwait c%0d got %b exp %b", cyc, dut_out, exp);
            end
            if (md_done) break;
            tick();
        end while (cyc < 50);
        checks++;
        if (!md_done || cyc != 35) begin
            errors++;
            $display("FAIL div_mwait_done got cyc=%0d exp cyc=35", cyc);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_exception();
        int dones;
        dones = 0;
        e_md_start = 1; e_md_isDiv = 1;
        for (int c = 1; c < 10; c++) begin
            #1;
            if (md_done) dones++;
            tick();
        end
        exception = 1;
        #1;
        checks++;
        if (dut_out !== 10'b0000_1110_00) begin
            errors++;
            $display("FAIL exc_cycle got %b exp %b", dut_out, 10'b0000_1110_00);
        end
        tick();
        exception = 0; e_md_start = 0;
        #1;
        checks++;
        if (dut_out !== 10'b0000_1000_00) begin
            errors++;
            $display("FAIL exc_flush got %b exp %b", dut_out, 10'b0000_1000_00);
        end
        tick();
        for (int c = 0; c < 30; c++) begin
            #1;
            if (md_done) dones++;
            tick();
        end
        checks++;
        if (dones != 0 || dut_out !== 10'b0) begin
            errors++;
            $display("FAIL exc_abort got dones=%0d out=%b exp dones=0 out=0", dones, dut_out);
        end
    endtask

    task automatic test_fetch_wait();
        logic [9:0] want;
        idle_inputs();
        i_req = 1;
        for (int j = 1; j >= 0; j--) begin
            d_isJumpInstr = j[0];
            want = j ? 10'b1100_0100_00 : 10'b1000_1000_00;
            for (int c = 0; c < 3; c++) begin
                #1;
                checks++;
                if (dut_out !== want) begin
                    errors++;
                    $display("FAIL fetch_wait j%0d c%0d got %b exp %b", j, c, dut_out, want);
                end
                tick();
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [9:0] exp;
        for (int c = 0; c < 4000; c++) begin
            resetn        = ($urandom_range(0, 127) != 0);
            d_src1        = 5'($urandom_range(0, 3));
            d_src2        = 5'($urandom_range(0, 3));
            e_dst         = 5'($urandom_range(0, 3));
            d_isJumpInstr = 1'($urandom);
            e_isLoad      = 1'($urandom);
            e_md_start    = ($urandom_range(0, 7) == 0);
            e_md_isDiv    = 1'($urandom);
            i_req         = 1'($urandom);
            i_data_ok     = 1'($urandom);
            m_req         = ($urandom_range(0, 3) == 0);
            m_data_ok     = 1'($urandom);
            exception     = ($urandom_range(0, 63) == 0);
            #1;
            exp = model_out();
            checks++;
            if (dut_out !== exp) begin
                errors++;
                $display("FAIL random c%0d got %b exp %b", c, dut_out, exp);
            end
            checks++;
            if (resetn && ((F_stall && 1'b0) || (D_stall && D_bubble) ||
                (E_stall && E_bubble) || (M_stall && M_bubble))) begin
                errors++;
                $display("FAIL stall_bubble c%0d got %b exp no stall+bubble", c, dut_out);
            end
            tick();
        end
        resetn = 1;
        idle_inputs();
        tick();
    endtask

    initial begin
        md_active = 0; md_elapsed = 0; md_lat = MUL_LAT; flushing = 0;
        resetn = 0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_mul_div();
        test_div_mwait();
        test_exception();
        test_fetch_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/bubble scheduler for the 5-stage pipeline.
- Drives F_stall, D_stall/D_bubble, E_stall/E_bubble, M_stall/M_bubble and W_bubble into the stage registers, using decode operand indices, execute-stage load/mul-div status, memory handshakes and the exception signal.
- Owns a small FSM and a latency counter that sequence multi-cycle MUL/DIV.
- Enforces a fixed priority: exception > data-memory wait > mul/div busy > load-use > branch delay-slot fetch wait > instruction fetch wait.

Parameters:
- MUL_LAT, 4, total cycles a MUL/MULT instruction occupies E (must be >= 2)
- DIV_LAT, 32, total cycles a DIV/DIVU instruction occupies E (must be >= 2)

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous reset, active-low
- d_src1  input  5  decode source register 1 index
- d_src2  input  5  decode source register 2 index
- d_isJumpInstr  input  1  instruction in D is a branch/jump
- e_dst  input  5  execute destination register
- e_isLoad  input  1  instruction in E is a load
- e_md_start  input  1  instruction in E is mul/div (level, held while in E)
- e_md_isDiv  input  1  selects DIV_LAT, else MUL_LAT
- i_req  input  1  fetch request outstanding
- i_data_ok  input  1  fetch data returned this cycle
- m_req  input  1  data-memory request outstanding
- m_data_ok  input  1  data-memory response this cycle
- exception  input  1  exception/ERET flush from M
- F_stall, D_stall, E_stall, M_stall  output  1 each  hold stage register
- D_bubble, E_bubble, M_bubble, W_bubble  output  1 each  insert NOP into stage register
- md_busy  output  1  mul/div stall active
- md_done  output  1  one-cycle pulse when the mul/div result is released from E

Behaviour:
- Reset (resetn=0 at posedge): state<=RUN, cnt<=0.
- While resetn=0, outputs are forced: all stalls=0, all bubbles=1, md_busy=0, md_done=0.
- Outputs are combinational from registered state/cnt and current inputs; zero-cycle latency.
- FSM states: RUN, MD_WAIT, FLUSH.
- cnt is 5 bits wide, sized for max(MUL_LAT,DIV_LAT)-2.
- Derived signals:
  - m_wait = m_req & ~m_data_ok
  - i_wait = i_req & ~i_data_ok
  - lu = e_isLoad & e_dst!=0 & (e_dst==d_src1 | e_dst==d_src2)
  - md_stall = (state==RUN & e_md_start) | (state==MD_WAIT & cnt!=0) | (state==MD_WAIT & cnt==0 & m_wait)
- Output priority (first matching rule wins; unlisted outputs are 0):
  1. exception: D_bubble=E_bubble=M_bubble=1. Next state FLUSH, cnt<=0.
  2. state==FLUSH: D_bubble=1 (discards the wrong-path fetch). Next state RUN unless exception is asserted again (then stay in FLUSH).
  3. m_wait: F_stall=D_stall=E_stall=M_stall=1, W_bubble=1.
  4. md_stall: F_stall=D_stall=E_stall=1, M_bubble=1, md_busy=1.
  5. lu: F_stall=D_stall=1, E_bubble=1.
  6. i_wait & d_isJumpInstr: F_stall=D_stall=1, E_bubble=1 (the branch holds until its delay slot arrives).
  7. i_wait: F_stall=1, D_bubble=1.
- MUL/DIV sequencing:
  - In RUN with e_md_start=1 and no exception: cnt<=(isDiv?DIV_LAT:MUL_LAT)-2, state<=MD_WAIT.
  - In MD_WAIT: if cnt!=0, cnt decrements every cycle, including under m_wait (the unit free-runs).
  - In MD_WAIT with cnt==0 and no m_wait: md_done=1, state<=RUN. E advances this cycle.
  - In MD_WAIT with cnt==0 and m_wait: hold in MD_WAIT at cnt=0, md_done=0.
  - e_md_start is ignored in MD_WAIT.
  - E therefore holds a mul/div for exactly LAT cycles when m_wait is absent.
  - A new e_md_start on the cycle after md_done starts a fresh sequence.
- Exception during MD_WAIT aborts the sequence: md_done never pulses and cnt clears.
- A load-use condition coincident with md_stall yields the md_stall outputs only; lu is re-evaluated afterwards.
- No stage is ever driven with stall=1 and bubble=1 simultaneously.
- A register index of 0 never causes a load-use stall.

Test Plan:
- Reset: resetn=0 for 2 cycles → all bubbles=1, all stalls=0. Release → outputs 0, state RUN.
- Load-use: e_isLoad=1, e_dst=5, d_src2=5 for one cycle → F_stall=D_stall=E_bubble=1. Repeat with e_dst=0 → no stall.
- MUL then DIV: e_md_start=1, e_md_isDiv=0 held → md_busy high for 3 cycles, md_done pulses on the 4th cycle. Then isDiv=1 → 31 busy cycles, md_done on the 32nd.
- DIV with m_wait: m_wait asserted cycles 30-34 of a DIV → md_done delayed until the first cycle with m_wait=0. M_stall=1 and W_bubble=1 throughout the wait.
- Exception mid-DIV at cycle 10 → D/E/M_bubble=1 that cycle, D_bubble=1 next cycle, then RUN; md_done never pulses.
- Fetch wait: i_wait 3 cycles with d_isJumpInstr=1 → D_stall=E_bubble=1 each cycle. Same with d_isJumpInstr=0 → F_stall=D_bubble=1 only.
